wb_classic_arbiter: RTL and testbench

//  Shares one Wishbone classic slave port among g_num_masters testbench/RTL masters.

---
 rtl/wb_classic_arbiter_pkg.sv | 21 ++
 rtl/wb_classic_arbiter_if.sv | 48 ++++
 rtl/wb_classic_arbiter_rr_picker.sv | 33 +++
 rtl/wb_classic_arbiter.sv | 152 +++++++++++++++
 tb/tb_wb_classic_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_classic_arbiter_pkg.sv
// Shared definitions for the Wishbone classic round-robin arbiter.
//   t_arb_state   : arbiter FSM state (idle / a master holds the bus)
//   c_max_masters : largest supported number of masters
//   onehot2bin    : converts a one-hot grant vector to a master index
package wb_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} t_arb_state;

  localparam int c_max_masters = 8;
  localparam int c_idx_w       = $clog2(c_max_masters);

  function automatic logic [c_idx_w-1:0] onehot2bin(input logic [c_max_masters-1:0] oh);
    logic [c_idx_w-1:0] bin;
    bin = '0;
    for (int i = 0; i < c_max_masters; i++) begin
      if (oh[i]) bin = bin | c_idx_w'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/wb_classic_arbiter_if.sv
// Bus bundle between the classic masters, the arbiter and the shared slave.
//   m_*  : per-master request side (cyc/stb/we/adr/dat/sel in, ack/err out),
//          master k occupies slice [k*W +: W] of the packed vectors
//   m_dat_o : read data broadcast to all masters
//   s_*  : single shared slave side
//   grant_o : one-hot current grant for debug/coverage
// Modports:
//   slave  : the arbiter's view (it is the slave of every master)
//   master : the environment's view (masters plus the shared slave)
interface wb_classic_arbiter_if #(
  parameter int g_num_masters = 2,
  parameter int g_addr_width  = 32,
  parameter int g_data_width  = 32
);
  import wb_arb_pkg::*;

  logic [g_num_masters-1:0]                  m_cyc_i;
  logic [g_num_masters-1:0]                  m_stb_i;
  logic [g_num_masters-1:0]                  m_we_i;
  logic [g_num_masters*g_addr_width-1:0]     m_adr_i;
  logic [g_num_masters*g_data_width-1:0]     m_dat_i;
  logic [g_num_masters*g_data_width/8-1:0]   m_sel_i;
  logic [g_num_masters-1:0]                  m_ack_o;
  logic [g_num_masters-1:0]                  m_err_o;
  logic [g_data_width-1:0]                   m_dat_o;
  logic                                      s_cyc_o;
  logic                                      s_stb_o;
  logic                                      s_we_o;
  logic [g_addr_width-1:0]                   s_adr_o;
  logic [g_data_width-1:0]                   s_dat_o;
  logic [g_data_width/8-1:0]                 s_sel_o;
  logic                                      s_ack_i;
  logic [g_data_width-1:0]                   s_dat_i;
  logic [g_num_masters-1:0]                  grant_o;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    output m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
           s_sel_o, grant_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_err_o, m_dat_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o,
           s_sel_o, grant_o
  );

endinterface

// File: rtl/wb_classic_arbiter_rr_picker.sv
// Rotating-priority encoder (module wb_rr_picker).
//   req  : request vector, one bit per master
//   last : index of the most recently served master
//   gnt  : one-hot winner, first set request scanning upward from last+1
//          with wrap-around; all zero when nothing is requested
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int g_num_masters = 2,
  parameter int c_lw          = $clog2(g_num_masters)
) (
  input  logic [g_num_masters-1:0] req,
  input  logic [c_lw-1:0]          last,
  output logic [g_num_masters-1:0] gnt
);

  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    // last itself is visited last, so the previous owner has lowest priority
    for (int k = 1; k <= g_num_masters; k++) begin
      idx = (int'(last) + k) % g_num_masters;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_classic_arbiter.sv
// Wishbone classic round-robin arbiter: shares one slave port among
// g_num_masters masters. A grant is held for the whole bus cycle (while the
// owner keeps cyc high), so locked multi-access cycles stay atomic. At least
// one idle cycle separates consecutive grants.
// Ports:
//   clk_i   : system clock
//   rst_n_i : asynchronous reset, active low
//   bus     : wb_classic_arbiter_if.slave bundle (master side, slave side, grant_o)
// Optional feature: define WB_ARB_TIMEOUT_EN to abort a slave access that
// stalls g_timeout cycles (m_err_o pulse, s_stb_o forced low until the owner
// drops cyc). Without it m_err_o is tied low and the slave may stall forever.
module wb_classic_arbiter
  import wb_arb_pkg::*;
#(
  parameter int g_num_masters = 2,
  parameter int g_addr_width  = 32,
  parameter int g_data_width  = 32,
  parameter int g_timeout     = 255
) (
  input logic                clk_i,
  input logic                rst_n_i,
  wb_classic_arbiter_if.slave bus
);

  localparam int c_n  = g_num_masters;
  localparam int c_aw = g_addr_width;
  localparam int c_dw = g_data_width;
  localparam int c_sw = g_data_width / 8;
  localparam int c_lw = $clog2(g_num_masters);

  if (g_num_masters < 2 || g_num_masters > c_max_masters) begin : g_bad_masters
    $error("wb_classic_arbiter: g_num_masters must be 2..8");
  end
  if (g_timeout < 1) begin : g_bad_timeout
    $error("wb_classic_arbiter: g_timeout must be >= 1");
  end

  t_arb_state       state_q, state_d;
  logic [c_n-1:0]   grant_q, grant_d;
  logic [c_lw-1:0]  last_q, last_d;
  logic [c_n-1:0]   req, pick;
  logic [c_lw-1:0]  gidx;
  logic             stb_kill;

  assign req  = bus.m_cyc_i & bus.m_stb_i;
  assign gidx = c_lw'(onehot2bin(c_max_masters'(grant_q)));

  wb_rr_picker #(
    .g_num_masters (c_n),
    .c_lw          (c_lw)
  ) u_picker (
    .req  (req),
    .last (last_q),
    .gnt  (pick)
  );

  // last starts at N-1 so master 0 has top priority after reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= c_lw'(c_n - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          grant_d = pick;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        // only the owner's cyc ends the grant; stb gaps keep the lock
        if (!bus.m_cyc_i[gidx]) begin
          last_d  = gidx;
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.m_ack_o = '0;
    if (state_q == ARB_GRANT) begin
      bus.s_cyc_o = bus.m_cyc_i[gidx];
      bus.s_stb_o = bus.m_stb_i[gidx] & ~stb_kill;
      bus.s_we_o  = bus.m_we_i[gidx];
      bus.s_adr_o = bus.m_adr_i[gidx*c_aw +: c_aw];
      bus.s_dat_o = bus.m_dat_i[gidx*c_dw +: c_dw];
      bus.s_sel_o = bus.m_sel_i[gidx*c_sw +: c_sw];
      bus.m_ack_o = grant_q & {c_n{bus.s_ack_i}};
    end
  end

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.grant_o = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int c_tw = ($clog2(g_timeout + 1) > 8) ? $clog2(g_timeout + 1) : 8;

  logic [c_tw-1:0] tmo_cnt_q;
  logic            tmo_err_q;
  logic            tmo_kill_q;

  // counts stalled strobe cycles; the abort latches stb low until the grant ends
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_cnt_q  <= '0;
      tmo_err_q  <= 1'b0;
      tmo_kill_q <= 1'b0;
    end else begin
      tmo_err_q <= 1'b0;
      if (state_q == ARB_IDLE) begin
        tmo_cnt_q  <= '0;
        tmo_kill_q <= 1'b0;
      end else if (bus.s_ack_i) begin
        tmo_cnt_q <= '0;
      end else if (bus.s_stb_o) begin
        tmo_cnt_q <= tmo_cnt_q + c_tw'(1);
        if (tmo_cnt_q == c_tw'(g_timeout - 1)) begin
          tmo_err_q  <= 1'b1;
          tmo_kill_q <= 1'b1;
        end
      end
    end
  end

  assign stb_kill    = tmo_kill_q;
  assign bus.m_err_o = grant_q & {c_n{tmo_err_q}};
`else
  assign stb_kill    = 1'b0;
  assign bus.m_err_o = '0;
`endif

endmodule

// File: tb/tb_wb_classic_arbiter.sv
module tb_wb_classic_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: owner index (-1 when idle), last served index
  int owner = -1;
  int last  = N - 1;
  int tcnt  = 0;
  bit kill  = 1'b0;
  bit errp  = 1'b0;

  wb_classic_arbiter_if #(.g_num_masters(N), .g_addr_width(AW), .g_data_width(DW)) bus ();

  wb_classic_arbiter #(
    .g_num_masters (N),
    .g_addr_width  (AW),
    .g_data_width  (DW),
    .g_timeout     (TO)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    last  = N - 1;
    tcnt  = 0;
    kill  = 1'b0;
    errp  = 1'b0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
`ifdef WB_ARB_TIMEOUT_EN
    errp = 1'b0;
    if (owner < 0) begin
      tcnt = 0;
      kill = 1'b0;
    end else if (bus.s_ack_i) begin
      tcnt = 0;
    end else if (bus.m_stb_i[owner] && !kill) begin
      tcnt++;
      if (tcnt == TO) begin
        errp = 1'b1;
        kill = 1'b1;
      end
    end
`endif
    if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (last + k) % N;
        if (bus.m_cyc_i[c] && bus.m_stb_i[c]) begin
          owner = c;
          break;
        end
      end
    end else if (!bus.m_cyc_i[owner]) begin
      last  = owner;
      owner = -1;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0]  eg, ea, ee;
    logic          ecyc, estb, ewe;
    logic [AW-1:0] eadr;
    logic [DW-1:0] edat;
    logic [SW-1:0] esel;
    eg = '0; ea = '0; ee = '0;
    ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
    eadr = '0; edat = '0; esel = '0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      ea[owner] = bus.s_ack_i;
      ee[owner] = errp;
      ecyc = bus.m_cyc_i[owner];
      estb = bus.m_stb_i[owner] & ~kill;
      ewe  = bus.m_we_i[owner];
      eadr = bus.m_adr_i[owner*AW +: AW];
      edat = bus.m_dat_i[owner*DW +: DW];
      esel = bus.m_sel_i[owner*SW +: SW];
    end
    chk("grant", bus.grant_o, eg);
    chk("m_ack", bus.m_ack_o, ea);
    chk("m_err", bus.m_err_o, ee);
    chk("s_cyc", bus.s_cyc_o, ecyc);
    chk("s_stb", bus.s_stb_o, estb);
    chk("s_we",  bus.s_we_o,  ewe);
    chk("s_adr", bus.s_adr_o, eadr);
    chk("s_dat", bus.s_dat_o, edat);
    chk("s_sel", bus.s_sel_o, esel);
    chk("m_dat", bus.m_dat_o, bus.s_dat_i);
  endtask

  task automatic settle();
    #1;
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_m(input int k, input bit cyc, input bit stb, input bit we,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sel);
    bus.m_cyc_i[k] = cyc;
    bus.m_stb_i[k] = stb;
    bus.m_we_i[k]  = we;
    bus.m_adr_i[k*AW +: AW] = adr;
    bus.m_dat_i[k*DW +: DW] = dat;
    bus.m_sel_i[k*SW +: SW] = sel;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < N; k++) set_m(k, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = $urandom;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    settle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  initial begin
    logic [N-1:0] pend, g, prev_g;
    bit           ack_nx;
    int           order[$];
    int           gaps[$];
    int           idle_run, acks0, acks1, pulses, errs, first_err, stb_low;
    logic [N-1:0] errv;
    logic         stbv;

    // single master write, reset values, grant latency and release
    do_reset();
    settle();
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_scyc", bus.s_cyc_o, 0);
    chk("rst_ack", bus.m_ack_o, 0);
    chk("rst_err", bus.m_err_o, 0);
    set_m(1, 1'b1, 1'b1, 1'b1, 32'h10, 32'hA5, 4'hF);
    settle();
    chk("t1_pre_scyc", bus.s_cyc_o, 0);
    tick();
    settle();
    chk("t1_scyc", bus.s_cyc_o, 1);
    chk("t1_adr", bus.s_adr_o, 32'h10);
    chk("t1_dat", bus.s_dat_o, 32'hA5);
    chk("t1_grant", bus.grant_o, 3'b010);
    tick();
    bus.s_ack_i = 1'b1;
    settle();
    chk("t1_ack", bus.m_ack_o, 3'b010);
    tick();
    bus.s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    settle();
    chk("t1_drop_scyc", bus.s_cyc_o, 0);
    chk("t1_grant_hold", bus.grant_o, 3'b010);
    tick();
    settle();
    chk("t1_grant_clr", bus.grant_o, 0);
    tick();

    // three simultaneous single-access requesters
    do_reset();
    pend = '1; ack_nx = 1'b0; prev_g = '0; idle_run = 0;
    for (int c = 0; c < 40 && pend != 0; c++) begin
      for (int k = 0; k < N; k++) set_m(k, pend[k], pend[k], 1'b0, 32'(k * 16), 32'(k), 4'hF);
      bus.s_ack_i = ack_nx;
      settle();
      g = bus.grant_o;
      if (g != 0 && prev_g == 0) begin
        if (order.size() > 0) gaps.push_back(idle_run);
        order.push_back(oh_idx(g));
      end
      if (g == 0) idle_run++;
      else idle_run = 0;
      if (g != 0 && bus.s_ack_i) begin
        pend   = pend & ~g;
        ack_nx = 1'b0;
      end else if (g != 0 && bus.s_stb_o) begin
        ack_nx = 1'b1;
      end
      prev_g = g;
      tick();
    end
    chk("t2_all_served", pend, 0);
    chk("t2_n_grants", order.size(), 3);
    foreach (order[i]) chk("t2_order", order[i], i);
    foreach (gaps[i]) chk("t2_dead_cycle", gaps[i], 1);

    // locked 4-read cycle by m0 while m1 keeps requesting
    do_reset();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h20, '0, 4'hF);
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h30, '0, 4'hF);
    settle();
    tick();
    acks0 = 0; acks1 = 0;
    for (int i = 0; i < 8; i++) begin
      bus.m_stb_i[0] = (i % 2 == 0);
      bus.s_ack_i    = (i % 2 == 0);
      bus.s_dat_i    = $urandom;
      settle();
      acks0 += int'(bus.m_ack_o[0]);
      acks1 += int'(bus.m_ack_o[1]);
      tick();
    end
    chk("t3_acks_m0", acks0, 4);
    set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    bus.s_ack_i = 1'b0;
    settle();
    chk("t3_hold", bus.grant_o, 3'b001);
    tick();
    settle();
    chk("t3_dead", bus.grant_o, 0);
    tick();
    settle();
    chk("t3_m1_grant", bus.grant_o, 3'b010);
    chk("t3_acks_m1", acks1, 0);
    tick();

    // delayed slave read data to m1
    do_reset();
    set_m(1, 1'b1, 1'b1, 1'b0, 32'h44, '0, 4'hF);
    settle();
    tick();
    pulses = 0; acks0 = 0;
    for (int i = 0; i < 4; i++) begin
      bus.s_ack_i = (i == 3);
      bus.s_dat_i = (i == 3) ? 32'hDEADBEEF : $urandom;
      settle();
      if (i == 3) begin
        chk("t4_rdata", bus.m_dat_o, 32'hDEADBEEF);
        chk("t4_ack", bus.m_ack_o, 3'b010);
      end
      pulses += int'(bus.m_ack_o[1]);
      acks0  += int'(bus.m_ack_o[0]);
      tick();
    end
    bus.s_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    settle();
    pulses += int'(bus.m_ack_o[1]);
    tick();
    chk("t4_pulses", pulses, 1);
    chk("t4_m0_ack", acks0, 0);

    // reset while m0 waits for ack; m0 wins again afterwards
    do_reset();
    set_m(0, 1'b1, 1'b1, 1'b0, 32'h50, '0, 4'hF);
    set_m(2, 1'b1, 1'b1, 1'b0, 32'h60, '0, 4'hF);
    settle();
    tick();
    settle();
    chk("t5_granted", bus.grant_o, 3'b001);
    tick();
    rst_n = 1'b0;
    model_reset();
    bus.s_ack_i = 1'b1;
    settle();
    chk("t5_scyc", bus.s_cyc_o, 0);
    chk("t5_ack", bus.m_ack_o, 0);
    chk("t5_grant", bus.grant_o, 0);
    tick();
    bus.s_ack_i = 1'b0;
    rst_n = 1'b1;
    settle();
    tick();
    settle();
    chk("t5_retry", bus.grant_o, 3'b001);
    tick();

    // slave never acks
    do_reset();
    set_m(2, 1'b1, 1'b1, 1'b1, 32'h80, 32'h1234, 4'hF);
    settle();
    tick();
    errs = 0; first_err = -1; stb_low = 0; errv = '0; stbv = 1'b1;
    for (int i = 0; i < 24; i++) begin
      settle();
      if (bus.m_err_o != 0) begin
        errs++;
        if (first_err < 0) begin
          first_err = i;
          errv = bus.m_err_o;
          stbv = bus.s_stb_o;
        end
      end
      if (!bus.s_stb_o) stb_low++;
      tick();
    end
`ifdef WB_ARB_TIMEOUT_EN
    chk("t6_err_cycle", first_err, TO);
    chk("t6_err_vec", errv, 3'b100);
    chk("t6_stb_forced", stbv, 0);
    chk("t6_err_pulses", errs, 1);
`else
    chk("t6_no_err", errs, 0);
    chk("t6_stb_stalls", stb_low, 0);
`endif
    set_m(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    settle();
    tick();

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        bit cy;
        cy = bus.m_cyc_i[k];
        if ($urandom_range(0, 3) == 0) cy = ~cy;
        set_m(k, cy, cy & ($urandom_range(0, 3) != 0), 1'($urandom), $urandom, $urandom,
              SW'($urandom));
      end
      bus.s_ack_i = ($urandom_range(0, 2) == 0);
      bus.s_dat_i = $urandom;
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        model_reset();
        settle();
        tick();
        rst_n = 1'b1;
      end
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
